// File: rtl/dump_pkg.sv
// dump_pkg: shared FSM states and default stream geometry for the register dump sequencer
package dump_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HALT = 3'd1,
    LOAD = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_e;
  localparam int BYTE_W = 8;
  localparam int DEF_WIDTH = 32;
  localparam int BYTES_PER_WORD = DEF_WIDTH / BYTE_W;
endpackage

// File: rtl/reg_dump_ctrl_word_serializer.sv
// word_serializer: loads a word and emits it MSB-byte-first over valid/ready
module word_serializer #(
  parameter int WIDTH = dump_pkg::DEF_WIDTH,
  parameter int BYTE_W = dump_pkg::BYTE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              en,
  input  logic [WIDTH-1:0]  word,
  input  logic              ready,
  output logic              valid,
  output logic [BYTE_W-1:0] byte_out,
  output logic              last_byte_accepted
);
  localparam int BPW = WIDTH / BYTE_W;
  localparam int CW = BPW > 1 ? $clog2(BPW) : 1;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic accept;
  always_comb begin
    accept = en && ready;
    shift_d = load ? word : accept ? shift_q << BYTE_W : shift_q;
    cnt_d = load ? '0 : accept ? cnt_q + 1'b1 : cnt_q;
    last_byte_accepted = accept && cnt_q == CW'(BPW - 1);
  end
  assign valid = en;
  assign byte_out = shift_q[WIDTH-1 -: BYTE_W];
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl: halts the pipeline and streams every register out as bytes for the debug UART
module reg_dump_ctrl #(
  parameter int WIDTH = dump_pkg::DEF_WIDTH,
  parameter int WIDTH_ADD = 5,
  parameter int NUM_REGISTERS = 32,
  parameter int BYTE_W = dump_pkg::BYTE_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dump_start,
  input  logic [WIDTH_ADD-1:0] pipe_rs_add,
  input  logic                 pipe_write_enable,
  output logic [WIDTH_ADD-1:0] rf_read_add1,
  output logic                 rf_write_enable,
  input  logic [WIDTH-1:0]     rf_read_data1,
  output logic                 pipe_halt,
  output logic                 tx_valid,
  output logic [BYTE_W-1:0]    tx_byte,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done
);
  import dump_pkg::*;
  localparam int IW = NUM_REGISTERS > 1 ? $clog2(NUM_REGISTERS) : 1;
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic last;
  logic final_reg;
  word_serializer #(.WIDTH(WIDTH), .BYTE_W(BYTE_W)) u_ser (
    .clk(clk),
    .reset(reset),
    .load(state_q == LOAD),
    .en(state_q == SEND),
    .word(rf_read_data1),
    .ready(tx_ready),
    .valid(tx_valid),
    .byte_out(tx_byte),
    .last_byte_accepted(last)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    final_reg = idx_q == IW'(NUM_REGISTERS - 1);
    case (state_q)
      IDLE: state_d = dump_start ? HALT : IDLE;
      HALT: state_d = LOAD;
      LOAD: state_d = SEND;
      SEND: begin
        state_d = !last ? SEND : final_reg ? DONE : LOAD;
        idx_d = last && !final_reg ? idx_q + 1'b1 : idx_q;
      end
      default: begin
        state_d = IDLE;
        idx_d = '0;
      end
    endcase
  end
  // HALT still lets the in-flight write-back land; the walk itself must never be overwritten
  assign rf_write_enable = (state_q == IDLE || state_q == HALT) && pipe_write_enable;
  assign rf_read_add1 = state_q == IDLE ? pipe_rs_add : WIDTH_ADD'(idx_q);
  assign busy = state_q != IDLE;
  assign pipe_halt = busy;
  assign done = state_q == DONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
    end
  end
endmodule
